script_fetch: RTL and testbench

- Upstream neighbour of the script analyser. Owns the script program counter and reads the byte-wide, synchronous-read script memory.
- Assembles two consecutive bytes into the 16-bit script word the analyser decodes.
- Presents the word with a valid flag, then holds it until a step or jump request arrives.
- Replaces the free-running pc register inside the analyser. The analyser now consumes `pc` and `script` from this block and returns step/jump requests.

---
 rtl/script_pkg.sv | 36 +++
 rtl/script_fetch.sv | 139 +++++++++++++
 tb/tb_script_fetch.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/script_pkg.sv
// Shared definitions for the script fetch/analyse path: fetch FSM encoding,
// op_code values and the bit layout of a 16-bit script word.
package script_pkg;

  localparam logic [1:0] StateLo    = 2'd0;
  localparam logic [1:0] StateHi    = 2'd1;
  localparam logic [1:0] StateValid = 2'd2;
  localparam logic [1:0] StateHalt  = 2'd3;

  typedef enum logic [1:0] {
    StLo    = StateLo,
    StHi    = StateHi,
    StValid = StateValid,
    StHalt  = StateHalt
  } fetch_state_e;

  localparam logic [2:0] OpEnd    = 3'b000;
  localparam logic [2:0] OpAction = 3'b001;
  localparam logic [2:0] OpJump   = 3'b010;
  localparam logic [2:0] OpWait   = 3'b011;
  localparam logic [2:0] OpGame   = 3'b100;

  localparam int unsigned INumMsb  = 15;
  localparam int unsigned INumLsb  = 8;
  localparam int unsigned ISignMsb = 7;
  localparam int unsigned ISignLsb = 5;
  localparam int unsigned FuncMsb  = 4;
  localparam int unsigned FuncLsb  = 3;
  localparam int unsigned OpMsb    = 2;
  localparam int unsigned OpLsb    = 0;

  function automatic logic [2:0] op_code_of(input logic [15:0] word);
    return word[OpMsb:OpLsb];
  endfunction

endpackage

// File: rtl/script_fetch.sv
// Script program counter and two-byte fetch from a synchronous-read script
// memory; presents one 16-bit word and holds it until step or jump.
module script_fetch
  import script_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned MEM_LAT = 1,
  parameter logic [2:0]  END_OP  = OpEnd
) (
  input  logic              clk,
  input  logic              res,
  input  logic              step,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_pc,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       script,
  output logic              script_valid,
  output logic              halted
);

  localparam int unsigned   WaitW      = 2;
  localparam logic [WaitW-1:0] WaitLaunch = WaitW'(MEM_LAT - 1);
  // The first edge after reset is itself the launch edge, so one extra cycle.
  localparam logic [WaitW-1:0] WaitReset  = WaitW'(MEM_LAT);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       script_q, script_d;
  logic              script_valid_q, script_valid_d;
  logic              halted_q, halted_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic              hi_done_q, hi_done_d;

  logic              launch;
  logic [ADDR_W-1:0] launch_addr;
  logic [ADDR_W-1:0] jump_tgt;

  assign jump_tgt = jump_pc & {{(ADDR_W-1){1'b1}}, 1'b0};

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    mem_addr_d     = mem_addr_q;
    script_d       = script_q;
    script_valid_d = script_valid_q;
    halted_d       = halted_q;
    wait_d         = wait_q;
    hi_done_d      = hi_done_q;
    launch         = 1'b0;
    launch_addr    = pc_q;

    // A jump is accepted in every state and aborts any fetch in flight.
    if (jump_en) begin
      launch      = 1'b1;
      launch_addr = jump_tgt;
    end else begin
      unique case (state_q)
        StLo: begin
          if (wait_q == '0) begin
            script_d[7:0] = mem_rdata;
            mem_addr_d    = {pc_q[ADDR_W-1:1], 1'b1};
            wait_d        = WaitLaunch;
            state_d       = StHi;
          end else begin
            wait_d = wait_q - 1'b1;
          end
        end
        StHi: begin
          if (hi_done_q) begin
            script_valid_d = 1'b1;
            if (op_code_of(script_q) == END_OP) begin
              halted_d = 1'b1;
              state_d  = StHalt;
            end else begin
              state_d = StValid;
            end
          end else if (wait_q == '0) begin
            script_d[15:8] = mem_rdata;
            hi_done_d      = 1'b1;
          end else begin
            wait_d = wait_q - 1'b1;
          end
        end
        StValid: begin
          if (step) begin
            launch      = 1'b1;
            launch_addr = pc_q + ADDR_W'(2);
          end
        end
        StHalt: begin
        end
        default: begin
        end
      endcase
    end

    if (launch) begin
      pc_d           = launch_addr;
      mem_addr_d     = launch_addr;
      script_valid_d = 1'b0;
      halted_d       = 1'b0;
      wait_d         = WaitLaunch;
      hi_done_d      = 1'b0;
      state_d        = StLo;
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q        <= StLo;
      pc_q           <= '0;
      mem_addr_q     <= '0;
      script_q       <= '0;
      script_valid_q <= 1'b0;
      halted_q       <= 1'b0;
      wait_q         <= WaitReset;
      hi_done_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      mem_addr_q     <= mem_addr_d;
      script_q       <= script_d;
      script_valid_q <= script_valid_d;
      halted_q       <= halted_d;
      wait_q         <= wait_d;
      hi_done_q      <= hi_done_d;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign pc           = pc_q;
  assign script       = script_q;
  assign script_valid = script_valid_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_script_fetch.sv
// Bench for script_fetch: one instance with MEM_LAT=1 and one with MEM_LAT=2,
// each backed by a behavioural script memory, checked against a word model.
module tb_script_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        res1, res2, step, jump_en;
  logic [7:0]  jump_pc;
  logic [7:0]  mem_addr1, mem_addr2, pc1, pc2, rdata1, rdata2, rd2_q;
  logic [15:0] script1, script2;
  logic        valid1, valid2, halted1, halted2;
  logic [7:0]  mem [256];

  // Latency 1: data for the launched address is captured one edge later.
  assign rdata1 = mem[mem_addr1];
  always_ff @(posedge clk) rd2_q <= mem[mem_addr2];
  assign rdata2 = rd2_q;

  script_fetch #(.ADDR_W(8), .MEM_LAT(1), .END_OP(3'b000)) u_dut1 (
    .clk(clk), .res(res1), .step(step), .jump_en(jump_en), .jump_pc(jump_pc),
    .mem_addr(mem_addr1), .mem_rdata(rdata1), .pc(pc1), .script(script1),
    .script_valid(valid1), .halted(halted1)
  );

  script_fetch #(.ADDR_W(8), .MEM_LAT(2), .END_OP(3'b000)) u_dut2 (
    .clk(clk), .res(res2), .step(step), .jump_en(jump_en), .jump_pc(jump_pc),
    .mem_addr(mem_addr2), .mem_rdata(rdata2), .pc(pc2), .script(script2),
    .script_valid(valid2), .halted(halted2)
  );

  int sel = 0;
  int lat = 1;
  logic [7:0]  c_pc, c_addr;
  logic [15:0] c_script;
  logic        c_valid, c_halted;

  always_comb begin
    if (sel == 1) begin
      c_pc = pc2; c_addr = mem_addr2; c_script = script2; c_valid = valid2; c_halted = halted2;
    end else begin
      c_pc = pc1; c_addr = mem_addr1; c_script = script1; c_valid = valid1; c_halted = halted1;
    end
  end

  int total = 0;
  int bad = 0;

  function automatic logic [15:0] word_at(input logic [7:0] a);
    logic [7:0] lo;
    lo = a & 8'hFE;
    return {mem[lo + 8'd1], mem[lo]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!c_valid && n < 40);
    total++;
    if (!c_valid) begin
      bad++;
      $display("FAIL timeout: script_valid=0 after %0d cycles, want 1", n);
    end
  endtask

  task automatic restart_dut1();
    sel = 0; lat = 1; res2 = 1'b0;
    res1 = 1'b0; tick();
    res1 = 1'b1; tick();
  endtask

  task automatic test_reset();
    int n;
    sel = 0; lat = 1;
    res1 = 1'b0; res2 = 1'b0; step = 1'b0; jump_en = 1'b0; jump_pc = 8'h00;
    tick(); tick();
    total++; if (c_pc !== 8'h00) begin bad++; $display("FAIL rst_pc: got %h want 00", c_pc); end
    total++; if (c_addr !== 8'h00) begin bad++; $display("FAIL rst_addr: got %h want 00", c_addr); end
    total++; if (c_script !== 16'h0000) begin bad++; $display("FAIL rst_script: got %h want 0000", c_script); end
    total++; if (c_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", c_valid); end
    total++; if (c_halted !== 1'b0) begin bad++; $display("FAIL rst_halted: got %b want 0", c_halted); end
    res1 = 1'b1; tick();
    total++; if (c_addr !== 8'h00) begin bad++; $display("FAIL first_addr: got %h want 00", c_addr); end
    tick();
    total++; if (c_addr !== 8'h01) begin bad++; $display("FAIL second_addr: got %h want 01", c_addr); end
    tick();
    total++; if (c_valid !== 1'b0) begin bad++; $display("FAIL early_valid: got %b want 0", c_valid); end
    tick();
    total++; if (c_valid !== 1'b1) begin bad++; $display("FAIL valid_c3: got %b want 1", c_valid); end
    total++; if (c_script !== 16'h0521) begin bad++; $display("FAIL word0: got %h want 0521", c_script); end
    total++; if (c_pc !== 8'h00) begin bad++; $display("FAIL pc0: got %h want 00", c_pc); end
    n = 0;
  endtask

  task automatic test_step();
    int n;
    step = 1'b1; tick(); step = 1'b0;
    total++; if (c_valid !== 1'b0) begin bad++; $display("FAIL step_drop: got %b want 0", c_valid); end
    wait_valid(n);
    total++; if (n != 3) begin bad++; $display("FAIL step_lat: got %0d want 3", n); end
    total++; if (c_script !== 16'h0A22) begin bad++; $display("FAIL word2: got %h want 0a22", c_script); end
    total++; if (c_pc !== 8'h02) begin bad++; $display("FAIL pc2: got %h want 02", c_pc); end
  endtask

  task automatic test_wrap();
    int n;
    jump_pc = 8'hFF; jump_en = 1'b1; tick(); jump_en = 1'b0;
    total++; if (c_pc !== 8'hFE) begin bad++; $display("FAIL jump_even: got %h want fe", c_pc); end
    wait_valid(n);
    total++; if (c_script !== 16'h5A13) begin bad++; $display("FAIL wordfe: got %h want 5a13", c_script); end
    step = 1'b1; tick(); step = 1'b0;
    total++; if (c_pc !== 8'h00) begin bad++; $display("FAIL wrap_pc: got %h want 00", c_pc); end
    wait_valid(n);
    total++; if (c_script !== 16'h0521) begin bad++; $display("FAIL wrap_word: got %h want 0521", c_script); end
  endtask

  task automatic test_jump_step();
    int n;
    int drops;
    jump_pc = 8'h11; jump_en = 1'b1; step = 1'b1; tick(); jump_en = 1'b0; step = 1'b0;
    total++; if (c_pc !== 8'h10) begin bad++; $display("FAIL js_pc: got %h want 10", c_pc); end
    wait_valid(n);
    total++; if (n != 3) begin bad++; $display("FAIL js_lat: got %0d want 3", n); end
    total++; if (c_script !== 16'h7719) begin bad++; $display("FAIL js_word: got %h want 7719", c_script); end
    drops = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!c_valid) drops++;
    end
    total++; if (drops != 0 || c_pc !== 8'h10) begin
      bad++; $display("FAIL js_single: got drops=%0d pc=%h want drops=0 pc=10", drops, c_pc);
    end
  endtask

  task automatic test_jump_abort();
    int n;
    sel = 1; lat = 2; res1 = 1'b0;
    res2 = 1'b0; tick();
    res2 = 1'b1; tick();
    wait_valid(n);
    total++; if (n != 5) begin bad++; $display("FAIL l2_lat: got %0d want 5", n); end
    total++; if (c_script !== 16'h0521) begin bad++; $display("FAIL l2_word0: got %h want 0521", c_script); end
    step = 1'b1; tick(); step = 1'b0;
    jump_pc = 8'h40; jump_en = 1'b1; tick(); jump_en = 1'b0;
    wait_valid(n);
    total++; if (n != 5) begin bad++; $display("FAIL abort_lat: got %0d want 5", n); end
    total++; if (c_script !== 16'hE14C) begin bad++; $display("FAIL abort_word: got %h want e14c", c_script); end
    total++; if (c_pc !== 8'h40) begin bad++; $display("FAIL abort_pc: got %h want 40", c_pc); end
  endtask

  task automatic test_halt();
    int n;
    restart_dut1();
    wait_valid(n);
    jump_pc = 8'h20; jump_en = 1'b1; tick(); jump_en = 1'b0;
    wait_valid(n);
    total++; if (c_halted !== 1'b1) begin bad++; $display("FAIL halt_set: got %b want 1", c_halted); end
    total++; if (c_script !== 16'h3308) begin bad++; $display("FAIL halt_word: got %h want 3308", c_script); end
    step = 1'b1; tick(); step = 1'b0; tick();
    step = 1'b1; tick(); step = 1'b0; tick();
    total++; if (c_pc !== 8'h20 || c_valid !== 1'b1 || c_halted !== 1'b1) begin
      bad++; $display("FAIL halt_hold: got pc=%h v=%b h=%b want pc=20 v=1 h=1", c_pc, c_valid, c_halted);
    end
    jump_pc = 8'h00; jump_en = 1'b1; tick(); jump_en = 1'b0;
    total++; if (c_halted !== 1'b0 || c_valid !== 1'b0) begin
      bad++; $display("FAIL halt_exit: got h=%b v=%b want h=0 v=0", c_halted, c_valid);
    end
    wait_valid(n);
    total++; if (n != 3 || c_script !== 16'h0521) begin
      bad++; $display("FAIL halt_refetch: got n=%0d word=%h want n=3 word=0521", n, c_script);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    step = 1'b1; tick(); step = 1'b0;
    tick();
    res1 = 1'b0; tick();
    total++; if (c_pc !== 8'h00 || c_addr !== 8'h00 || c_script !== 16'h0000 ||
                 c_valid !== 1'b0 || c_halted !== 1'b0) begin
      bad++; $display("FAIL mid_rst: got pc=%h addr=%h w=%h v=%b h=%b want all zero",
                      c_pc, c_addr, c_script, c_valid, c_halted);
    end
    res1 = 1'b1; tick();
    wait_valid(n);
    total++; if (n != 3 || c_pc !== 8'h00 || c_script !== 16'h0521) begin
      bad++; $display("FAIL mid_restart: got n=%0d pc=%h w=%h want n=3 pc=00 w=0521", n, c_pc, c_script);
    end
  endtask

  task automatic test_random();
    int n, choice, inj, d, elapsed;
    logic [7:0] exp_pc, tgt;
    logic exp_halt;
    for (int i = 128; i < 256; i++) begin
      mem[i] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) mem[i][2:0] = 3'b000;
    end
    exp_pc = 8'h00;
    exp_halt = (mem[0][2:0] == 3'b000);
    for (int it = 0; it < 40; it++) begin
      choice = $urandom_range(0, 3);
      tgt = 8'($urandom_range(0, 255));
      if (choice == 3 || (choice == 0 && exp_halt)) begin
        for (int k = 0; k < $urandom_range(1, 3); k++) begin
          step = (choice == 0); tick(); step = 1'b0;
        end
        total++; if (c_pc !== exp_pc || c_valid !== 1'b1 || c_script !== word_at(exp_pc)) begin
          bad++; $display("FAIL rnd_hold: got pc=%h v=%b w=%h want pc=%h v=1 w=%h",
                          c_pc, c_valid, c_script, exp_pc, word_at(exp_pc));
        end
        continue;
      end
      jump_en = (choice != 0); jump_pc = tgt; step = (choice != 1);
      tick();
      jump_en = 1'b0; step = 1'b0;
      exp_pc = (choice == 0) ? exp_pc + 8'd2 : (tgt & 8'hFE);
      elapsed = 0;
      inj = $urandom_range(0, 3);
      d = $urandom_range(0, 2 * lat - 1);
      if (inj == 1 || inj == 2) begin
        for (int k = 0; k < d; k++) tick();
        elapsed = d + 1;
        if (inj == 1) begin
          step = 1'b1; tick(); step = 1'b0;
        end else begin
          tgt = 8'($urandom_range(0, 255));
          jump_pc = tgt; jump_en = 1'b1; tick(); jump_en = 1'b0;
          exp_pc = tgt & 8'hFE;
          elapsed = 0;
        end
      end
      wait_valid(n);
      exp_halt = (mem[exp_pc][2:0] == 3'b000);
      total++; if (n + elapsed != 2 * lat + 1) begin
        bad++; $display("FAIL rnd_lat: got %0d want %0d", n + elapsed, 2 * lat + 1);
      end
      total++; if (c_pc !== exp_pc || c_script !== word_at(exp_pc) || c_halted !== exp_halt) begin
        bad++; $display("FAIL rnd_word: got pc=%h w=%h h=%b want pc=%h w=%h h=%b",
                        c_pc, c_script, c_halted, exp_pc, word_at(exp_pc), exp_halt);
      end
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom) | 8'h01;
    mem[8'h00] = 8'h21; mem[8'h01] = 8'h05; mem[8'h02] = 8'h22; mem[8'h03] = 8'h0A;
    mem[8'h10] = 8'h19; mem[8'h11] = 8'h77; mem[8'h20] = 8'h08; mem[8'h21] = 8'h33;
    mem[8'h40] = 8'h4C; mem[8'h41] = 8'hE1; mem[8'hFE] = 8'h13; mem[8'hFF] = 8'h5A;
    test_reset();
    test_step();
    test_wrap();
    test_jump_step();
    test_jump_abort();
    test_halt();
    test_reset_mid();
    test_random();
    n = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
